// File: rtl/prime_generator.sv
// prime_generator
// Enumerates every prime from 2 up to a programmable inclusive limit, in
// ascending order, using iterative trial division (one divisor per clock,
// early exit once div*div exceeds the candidate). Each prime is offered on a
// valid/ready handshake.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   start        begin a run (sampled only while idle)
//   limit        inclusive upper bound, latched when start is accepted
//   prime_out    current prime, meaningful while prime_valid is high
//   prime_valid  prime_out holds a prime awaiting acceptance
//   prime_ready  consumer accepts prime_out when high with prime_valid
//   busy         high while testing candidates or offering a prime
//   done         one-cycle pulse at the end of a run
//   count        number of primes accepted in the current/last run
module prime_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] prime_out,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TEST = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_r, state_nxt_s, adv_state_s;
    logic [WIDTH-1:0] lim_r, lim_nxt_s;
    logic [WIDTH-1:0] cand_r, cand_nxt_s, adv_cand_s;
    logic [WIDTH-1:0] div_r, div_nxt_s;
    logic [WIDTH-1:0] count_r, count_nxt_s;
    logic [WIDTH-1:0] prime_out_r;
    logic             prime_valid_r, busy_r, done_r;

    logic [2*WIDTH-1:0] div_ext_s, cand_ext_s, div_sq_s;
    logic [WIDTH-1:0]   div_safe_s, rem_s;

    // The square is formed at double width so it can never overflow.
    assign div_ext_s  = {{WIDTH{1'b0}}, div_r};
    assign cand_ext_s = {{WIDTH{1'b0}}, cand_r};
    assign div_sq_s   = div_ext_s * div_ext_s;
    // div_r is only zero outside TEST; keep the modulo well-defined anyway.
    assign div_safe_s = (div_r == {WIDTH{1'b0}}) ? WIDTH'(1) : div_r;
    assign rem_s      = cand_r % div_safe_s;

    // Where to go after a candidate is finished (composite or accepted prime).
    // Stopping at the limit instead of incrementing prevents candidate wrap.
    always_comb begin
        adv_state_s = S_TEST;
        adv_cand_s  = cand_r + WIDTH'(1);
        if (cand_r == lim_r) begin
            adv_state_s = S_DONE;
            adv_cand_s  = cand_r;
        end else begin
            adv_state_s = S_TEST;
            adv_cand_s  = cand_r + WIDTH'(1);
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s = state_r;
        lim_nxt_s   = lim_r;
        cand_nxt_s  = cand_r;
        div_nxt_s   = div_r;
        count_nxt_s = count_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    lim_nxt_s   = limit;
                    count_nxt_s = {WIDTH{1'b0}};
                    if (limit < WIDTH'(2)) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        cand_nxt_s  = WIDTH'(2);
                        div_nxt_s   = WIDTH'(2);
                        state_nxt_s = S_TEST;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_TEST: begin
                if (div_sq_s > cand_ext_s) begin
                    state_nxt_s = S_EMIT;
                end else if (rem_s == {WIDTH{1'b0}}) begin
                    state_nxt_s = adv_state_s;
                    cand_nxt_s  = adv_cand_s;
                    div_nxt_s   = WIDTH'(2);
                end else begin
                    div_nxt_s = div_r + WIDTH'(1);
                end
            end
            S_EMIT: begin
                // prime_valid is high throughout EMIT, so ready alone completes it.
                if (prime_ready) begin
                    count_nxt_s = count_r + WIDTH'(1);
                    state_nxt_s = adv_state_s;
                    cand_nxt_s  = adv_cand_s;
                    div_nxt_s   = WIDTH'(2);
                end else begin
                    state_nxt_s = S_EMIT;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            lim_r         <= {WIDTH{1'b0}};
            cand_r        <= {WIDTH{1'b0}};
            div_r         <= {WIDTH{1'b0}};
            count_r       <= {WIDTH{1'b0}};
            prime_out_r   <= {WIDTH{1'b0}};
            prime_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            lim_r         <= lim_nxt_s;
            cand_r        <= cand_nxt_s;
            div_r         <= div_nxt_s;
            count_r       <= count_nxt_s;
            prime_valid_r <= (state_nxt_s == S_EMIT);
            busy_r        <= (state_nxt_s == S_TEST) || (state_nxt_s == S_EMIT);
            done_r        <= (state_nxt_s == S_DONE);
            if (state_nxt_s == S_EMIT) begin
                prime_out_r <= cand_nxt_s;
            end else begin
                prime_out_r <= prime_out_r;
            end
        end
    end

    assign prime_out   = prime_out_r;
    assign prime_valid = prime_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign count       = count_r;

endmodule

// File: tb/tb_prime_generator.sv
module tb_prime_generator;

    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] limit;
    logic [7:0] prime_out;
    logic       prime_valid;
    logic       prime_ready;
    logic       busy;
    logic       done;
    logic [7:0] count;

    prime_generator #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .limit      (limit),
        .prime_out  (prime_out),
        .prime_valid(prime_valid),
        .prime_ready(prime_ready),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // results of the last run
    int hs_val[$];
    int hs_t[$];
    int done_t;
    int viol;
    int valid_seen;

    typedef struct {
        int lim;
        int mode;       // 0 ready always, 1 five-cycle stall on first prime, 2 random
        int exp_count;
        int exp_last;
        int exp_done_t; // 0 = timing not checked
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d < n; d++) begin
            if ((n % d) == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_once(input int lim, input int mode);
        int stall;
        logic pv, pr, r;
        logic [7:0] po;
        hs_val.delete();
        hs_t.delete();
        done_t = -1;
        viol = 0;
        valid_seen = 0;
        stall = 0;
        pv = 1'b0;
        pr = 1'b0;
        po = 8'd0;
        @(negedge clk);
        limit = 8'(lim);
        start = 1'b1;
        prime_ready = 1'b0;
        for (int t = 1; t <= BUDGET; t++) begin
            @(negedge clk);
            start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (mode == 2) limit = 8'($urandom_range(0, 255));
            if (prime_valid) valid_seen++;
            if (done && prime_valid) viol++;
            if (pv && !pr && (!prime_valid || prime_out != po)) viol++;
            if (!done && !busy) viol++;
            if (done && busy) viol++;
            case (mode)
                0: r = 1'b1;
                1: begin
                    if (prime_valid && stall < 5) begin
                        r = 1'b0;
                        stall++;
                    end else begin
                        r = 1'b1;
                    end
                end
                default: r = 1'($urandom_range(0, 1));
            endcase
            prime_ready = r;
            if (prime_valid && r) begin
                hs_val.push_back(int'(prime_out));
                hs_t.push_back(t);
            end
            pv = prime_valid;
            pr = r;
            po = prime_out;
            if (done) begin
                done_t = t;
                break;
            end
        end
        start = 1'b0;
        prime_ready = 1'b0;
        if (done_t < 0) begin
            check("run_timeout", 0, 1);
        end
    endtask

    task automatic check_run(input int lim, input int exp_count, input int exp_last,
                             input int exp_done_t);
        int exp_list[$];
        int bad;
        for (int n = 2; n <= lim; n++) begin
            if (is_prime(n)) exp_list.push_back(n);
        end
        bad = 0;
        if (hs_val.size() != exp_list.size()) begin
            bad = 1;
        end else begin
            for (int i = 0; i < exp_list.size(); i++) begin
                if (hs_val[i] != exp_list[i]) bad++;
            end
        end
        check($sformatf("seq_mismatches lim=%0d", lim), bad, 0);
        check($sformatf("n_primes lim=%0d", lim), hs_val.size(), exp_count);
        if (exp_count > 0) begin
            check($sformatf("last_prime lim=%0d", lim), hs_val[hs_val.size()-1], exp_last);
        end else begin
            check($sformatf("valid_seen lim=%0d", lim), valid_seen, 0);
        end
        check($sformatf("protocol_viol lim=%0d", lim), viol, 0);
        if (exp_done_t != 0) begin
            check($sformatf("done_cycle lim=%0d", lim), done_t, exp_done_t);
        end
        // IDLE cycle after done: count held, no pulse, not busy
        @(negedge clk);
        check($sformatf("count lim=%0d", lim), int'(count), exp_count);
        check($sformatf("done_low_after lim=%0d", lim), int'(done), 0);
        check($sformatf("busy_idle lim=%0d", lim), int'(busy), 0);
    endtask

    initial begin
        int t10_fast[4];
        int t10_stall[4];
        int found;
        int extra;

        vecs[0] = '{lim: 10,  mode: 0, exp_count: 4,  exp_last: 7,   exp_done_t: 17};
        vecs[1] = '{lim: 10,  mode: 1, exp_count: 4,  exp_last: 7,   exp_done_t: 22};
        vecs[2] = '{lim: 0,   mode: 0, exp_count: 0,  exp_last: 0,   exp_done_t: 1};
        vecs[3] = '{lim: 1,   mode: 0, exp_count: 0,  exp_last: 0,   exp_done_t: 1};
        vecs[4] = '{lim: 2,   mode: 0, exp_count: 1,  exp_last: 2,   exp_done_t: 3};
        vecs[5] = '{lim: 3,   mode: 0, exp_count: 2,  exp_last: 3,   exp_done_t: 5};
        vecs[6] = '{lim: 255, mode: 2, exp_count: 54, exp_last: 251, exp_done_t: 0};
        vecs[7] = '{lim: 255, mode: 0, exp_count: 54, exp_last: 251, exp_done_t: 0};
        t10_fast  = '{2, 4, 8, 12};
        t10_stall = '{7, 9, 13, 17};

        rst = 1'b1;
        start = 1'b0;
        limit = 8'd0;
        prime_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_prime_out", int'(prime_out), 0);
        check("rst_prime_valid", int'(prime_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(count), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_once(vecs[i].lim, vecs[i].mode);
            check_run(vecs[i].lim, vecs[i].exp_count, vecs[i].exp_last, vecs[i].exp_done_t);
        end

        // handshake cycle positions for limit 10, with and without stall
        run_once(10, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fast_hs_t[%0d]", i), (hs_t.size() > i) ? hs_t[i] : -1, t10_fast[i]);
        end
        check_run(10, 4, 7, 17);
        run_once(10, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_hs_t[%0d]", i), (hs_t.size() > i) ? hs_t[i] : -1, t10_stall[i]);
        end
        check_run(10, 4, 7, 22);

        // reset while 5 is being offered
        @(negedge clk);
        limit = 8'd20;
        start = 1'b1;
        prime_ready = 1'b0;
        found = 0;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (prime_valid && prime_out == 8'd5) begin
                found = 1;
                break;
            end
            prime_ready = prime_valid;
        end
        check("rst_wait_for_5", found, 1);
        prime_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_prime_valid", int'(prime_valid), 0);
        check("midrst_prime_out", int'(prime_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_count", int'(count), 0);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || prime_valid || busy) extra++;
        end
        check("midrst_quiet", extra, 0);
        run_once(20, 0);
        check("restart_first", (hs_val.size() > 0) ? hs_val[0] : -1, 2);
        check_run(20, 8, 19, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
